// File: rtl/bht_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bht_pkg
// Description : Shared constants for the N-way branch history table: update
//               op encodings, flush FSM state encodings and the weakly-taken
//               counter initial value.
// Revision    : 1.0 - initial release
// ============================================================================
package bht_pkg;

    localparam int BHT_OP_NBIT = 2;

    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_NOP    = 2'b00;
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_TAKEN  = 2'b01;
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_NTAKEN = 2'b10;
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_FLUSH  = 2'b11;

    localparam int BHT_STATE_NBIT = 1;

    localparam logic [BHT_STATE_NBIT-1:0] S_IDLE  = 1'b0;
    localparam logic [BHT_STATE_NBIT-1:0] S_FLUSH = 1'b1;

    // Weakly-taken counter value: MSB set, all lower bits clear.
    function automatic logic [31:0] bht_weak_taken(input int cnt_nbit);
        return 32'd1 << (cnt_nbit - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_match.sv
`default_nettype none
// ============================================================================
// Module      : bht_match
// Description : Combinational tag compare across the ways of one set.
//               Returns the priority-encoded hit way (lowest wins) and the
//               lowest-numbered invalid way for allocation.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_match
    import bht_pkg::*;
#(
    parameter int NWAY     = 2,
    parameter int TAG_NBIT = 7,
    parameter int WAY_NBIT = 1
) (
    input  logic [NWAY-1:0]               i_valid,
    input  logic [NWAY-1:0][TAG_NBIT-1:0] i_tags,
    input  logic [TAG_NBIT-1:0]           i_tag,
    output logic                          o_hit,
    output logic [WAY_NBIT-1:0]           o_hit_way,
    output logic                          o_any_invalid,
    output logic [WAY_NBIT-1:0]           o_inv_way
);

    // Scan from the top way down so the lowest-numbered match/invalid wins.
    always_comb begin
        o_hit         = 1'b0;
        o_hit_way     = '0;
        o_any_invalid = 1'b0;
        o_inv_way     = '0;
        for (int i = NWAY - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_tags[i] == i_tag)) begin
                o_hit     = 1'b1;
                o_hit_way = WAY_NBIT'(i);
            end
            if (!i_valid[i]) begin
                o_any_invalid = 1'b1;
                o_inv_way     = WAY_NBIT'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bht_nway.sv
`default_nettype none
// ============================================================================
// Module      : bht_nway
// Description : N-way set-associative branch history table with saturating
//               counters, round-robin replacement and a sequenced flush that
//               clears one set per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_nway
    import bht_pkg::*;
#(
    parameter int ADDR_NBIT = 10,
    parameter int NSET      = 8,
    parameter int NWAY      = 2,
    parameter int CNT_NBIT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BHT_OP_NBIT-1:0] op,
    input  logic [ADDR_NBIT-1:0]   pc_w,
    input  logic [ADDR_NBIT-1:0]   dst_w,
    input  logic [ADDR_NBIT-1:0]   pc_r,
    output logic [ADDR_NBIT-1:0]   dst_r,
    output logic                   take_r,
    output logic                   hit_r,
    output logic                   busy
);

    localparam int c_idx_nbit = $clog2(NSET);
    localparam int c_tag_nbit = ADDR_NBIT - c_idx_nbit;
    localparam int c_way_nbit = (NWAY > 1) ? $clog2(NWAY) : 1;

    localparam logic [CNT_NBIT-1:0]   c_weak_cnt = CNT_NBIT'(bht_weak_taken(CNT_NBIT));
    localparam logic [c_way_nbit-1:0] c_last_way = c_way_nbit'(NWAY - 1);
    localparam logic [c_idx_nbit-1:0] c_last_set = c_idx_nbit'(NSET - 1);

    // Table storage: valid and victim pointer are reset, payload is not.
    logic [NWAY-1:0]                 r_valid [NSET];
    logic [c_way_nbit-1:0]           r_ptr   [NSET];
    logic [NWAY-1:0][c_tag_nbit-1:0] r_tag   [NSET];
    logic [NWAY-1:0][ADDR_NBIT-1:0]  r_dst   [NSET];
    logic [NWAY-1:0][CNT_NBIT-1:0]   r_cnt   [NSET];

    logic [BHT_STATE_NBIT-1:0] r_state;
    logic [BHT_STATE_NBIT-1:0] w_state_nxt;
    logic [c_idx_nbit-1:0]     r_flush_set;
    logic [c_idx_nbit-1:0]     w_flush_set_nxt;

    // Read port decode.
    logic [c_idx_nbit-1:0] w_rd_idx;
    logic [c_tag_nbit-1:0] w_rd_tag;
    logic                  w_rd_hit;
    logic [c_way_nbit-1:0] w_rd_way;
    logic                  w_rd_unused_any_inv;
    logic [c_way_nbit-1:0] w_rd_unused_inv_way;

    // Write port decode.
    logic [c_idx_nbit-1:0] w_wr_idx;
    logic [c_tag_nbit-1:0] w_wr_tag;
    logic                  w_wr_hit;
    logic [c_way_nbit-1:0] w_wr_way;
    logic                  w_wr_any_inv;
    logic [c_way_nbit-1:0] w_wr_inv_way;

    logic                  w_accept;
    logic                  w_alloc;
    logic                  w_hit_taken;
    logic                  w_hit_ntaken;
    logic [c_way_nbit-1:0] w_victim;
    logic [c_way_nbit-1:0] w_ptr_nxt;
    logic [CNT_NBIT-1:0]   w_wr_cnt;

    assign w_rd_idx = pc_r[c_idx_nbit-1:0];
    assign w_rd_tag = pc_r[ADDR_NBIT-1:c_idx_nbit];
    assign w_wr_idx = pc_w[c_idx_nbit-1:0];
    assign w_wr_tag = pc_w[ADDR_NBIT-1:c_idx_nbit];

    bht_match #(
        .NWAY     (NWAY),
        .TAG_NBIT (c_tag_nbit),
        .WAY_NBIT (c_way_nbit)
    ) u_match_rd (
        .i_valid       (r_valid[w_rd_idx]),
        .i_tags        (r_tag[w_rd_idx]),
        .i_tag         (w_rd_tag),
        .o_hit         (w_rd_hit),
        .o_hit_way     (w_rd_way),
        .o_any_invalid (w_rd_unused_any_inv),
        .o_inv_way     (w_rd_unused_inv_way)
    );

    bht_match #(
        .NWAY     (NWAY),
        .TAG_NBIT (c_tag_nbit),
        .WAY_NBIT (c_way_nbit)
    ) u_match_wr (
        .i_valid       (r_valid[w_wr_idx]),
        .i_tags        (r_tag[w_wr_idx]),
        .i_tag         (w_wr_tag),
        .o_hit         (w_wr_hit),
        .o_hit_way     (w_wr_way),
        .o_any_invalid (w_wr_any_inv),
        .o_inv_way     (w_wr_inv_way)
    );

    assign busy   = (r_state == S_FLUSH);
    assign hit_r  = w_rd_hit;
    assign take_r = w_rd_hit & r_cnt[w_rd_idx][w_rd_way][CNT_NBIT-1] & ~busy;
    assign dst_r  = w_rd_hit ? r_dst[w_rd_idx][w_rd_way] : '0;

    // Every op, FLUSH included, is dropped while a flush is sequencing.
    assign w_accept     = ~busy;
    assign w_alloc      = w_accept & (op == BHT_OP_TAKEN)  & ~w_wr_hit;
    assign w_hit_taken  = w_accept & (op == BHT_OP_TAKEN)  &  w_wr_hit;
    assign w_hit_ntaken = w_accept & (op == BHT_OP_NTAKEN) &  w_wr_hit;
    assign w_victim     = w_wr_any_inv ? w_wr_inv_way : r_ptr[w_wr_idx];
    assign w_ptr_nxt    = (r_ptr[w_wr_idx] == c_last_way) ? '0
                                                          : r_ptr[w_wr_idx] + 1'b1;
    assign w_wr_cnt     = r_cnt[w_wr_idx][w_wr_way];

    // Flush FSM state and set counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flush_set <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_set <= w_flush_set_nxt;
        end
    end

    // Flush FSM next state: walk sets 0..NSET-1, then return to idle.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_set_nxt = r_flush_set;
        case (r_state)
            S_IDLE: begin
                if (op == BHT_OP_FLUSH) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_set_nxt = '0;
                end
            end
            S_FLUSH: begin
                w_flush_set_nxt = r_flush_set + 1'b1;
                if (r_flush_set == c_last_set) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Valid bits and victim pointers: cleared by reset/flush, set on allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSET; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (busy) begin
            r_valid[r_flush_set] <= '0;
            r_ptr[r_flush_set]   <= '0;
        end else if (w_alloc) begin
            r_valid[w_wr_idx][w_victim] <= 1'b1;
            r_ptr[w_wr_idx]             <= w_ptr_nxt;
        end
    end

    // Entry payload: fill on allocation, saturating counter update on a hit.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_wr_idx][w_victim] <= w_wr_tag;
            r_dst[w_wr_idx][w_victim] <= dst_w;
            r_cnt[w_wr_idx][w_victim] <= c_weak_cnt;
        end else if (w_hit_taken) begin
            r_dst[w_wr_idx][w_wr_way] <= dst_w;
            if (w_wr_cnt != '1) begin
                r_cnt[w_wr_idx][w_wr_way] <= w_wr_cnt + 1'b1;
            end
        end else if (w_hit_ntaken) begin
            if (w_wr_cnt != '0) begin
                r_cnt[w_wr_idx][w_wr_way] <= w_wr_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
